// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
//   - ld_op encodings
//   - EXE->MEM and MEM->WB bus widths, field offsets and packed struct views
package mem_stage_pkg;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_op_e;

  localparam int ES2MS_BUS_W = 74;
  localparam int MS2WS_BUS_W = 70;

  // es2ms_bus = {pc, alu_result, res_from_mem, ld_op, dest, gr_we}
  localparam int ES_GR_WE     = 0;
  localparam int ES_DEST_LSB  = 1;
  localparam int ES_LD_OP_LSB = 6;
  localparam int ES_RES_MEM   = 9;
  localparam int ES_ALU_LSB   = 10;
  localparam int ES_PC_LSB    = 42;

  // ms2ws_bus = {pc, final_result, gr_we, dest}
  localparam int MS_DEST_LSB  = 0;
  localparam int MS_GR_WE     = 5;
  localparam int MS_RES_LSB   = 6;
  localparam int MS_PC_LSB    = 38;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic [4:0]  dest;
    logic        gr_we;
  } es2ms_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] final_result;
    logic        gr_we;
    logic [4:0]  dest;
  } ms2ws_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational sub-word load extraction.
//   rdata  : 32-bit word read from data SRAM
//   addr   : low address bits selecting byte/halfword lane
//   ld_op  : load type (unknown encodings act as a full word)
//   data   : extracted, sign- or zero-extended result
// Present only when MEM_SUBWORD_LD_EN is defined.
`ifdef MEM_SUBWORD_LD_EN
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // addr[0] ignored for halfwords: misaligned accesses just use lane addr[1]
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (ld_op)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_BU:   data = {24'd0, byte_sel};
      LD_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule
`endif

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Registers the EXE->MEM bus, merges the
// synchronous SRAM read data (valid only in the first cycle after entry) and
// holds it in a buffer so the result stays stable across WB stalls.
// Ports:
//   clk, resetn            clock, async active-low reset
//   es2ms_valid/es2ms_bus  incoming instruction from EXE
//   ms_allowin             MEM can accept this cycle
//   ws_allowin             WB can accept
//   ms2ws_valid/ms2ws_bus  outgoing instruction to WB
//   data_sram_rdata        SRAM read data (cycle after EXE request)
//   mem_dest/mem_rf_we/mem_fwd_data/mem_is_load  hazard / forwarding info
// Config: define MEM_SUBWORD_LD_EN for byte/halfword loads; otherwise every
// load returns the full word.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   es2ms_valid,
  output logic                   ms_allowin,
  input  logic [ES2MS_BUS_W-1:0] es2ms_bus,
  input  logic                   ws_allowin,
  output logic                   ms2ws_valid,
  output logic [MS2WS_BUS_W-1:0] ms2ws_bus,
  input  logic [DATA_W-1:0]      data_sram_rdata,
  output logic [4:0]             mem_dest,
  output logic                   mem_rf_we,
  output logic [DATA_W-1:0]      mem_fwd_data,
  output logic                   mem_is_load
);

  es2ms_bus_t es_in;
  assign es_in = es2ms_bus;

  logic              ms_valid_q,     ms_valid_d;
  logic              first_cyc_q,    first_cyc_d;
  logic              buf_vld_q,      buf_vld_d;
  logic [DATA_W-1:0] rdata_buf_q,    rdata_buf_d;
  logic [31:0]       pc_q,           pc_d;
  logic [DATA_W-1:0] alu_result_q,   alu_result_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic [4:0]        dest_q,         dest_d;
  logic              gr_we_q,        gr_we_d;

  logic              accept;
  logic [DATA_W-1:0] rdata_eff;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  // ready_go is constant 1, so allowin depends only on WB
  assign ms_allowin = !ms_valid_q || ws_allowin;
  assign accept     = es2ms_valid && ms_allowin;

  always_comb begin
    ms_valid_d     = ms_allowin ? es2ms_valid : ms_valid_q;
    first_cyc_d    = accept;
    pc_d           = pc_q;
    alu_result_d   = alu_result_q;
    res_from_mem_d = res_from_mem_q;
    dest_d         = dest_q;
    gr_we_d        = gr_we_q;
    buf_vld_d      = buf_vld_q;
    rdata_buf_d    = rdata_buf_q;
    if (first_cyc_q && res_from_mem_q) begin
      buf_vld_d   = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
    // a new entry always starts with an empty buffer, even back-to-back
    if (accept) begin
      buf_vld_d      = 1'b0;
      pc_d           = es_in.pc;
      alu_result_d   = es_in.alu_result;
      res_from_mem_d = es_in.res_from_mem;
      dest_d         = es_in.dest;
      gr_we_d        = es_in.gr_we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      first_cyc_q    <= 1'b0;
      buf_vld_q      <= 1'b0;
      rdata_buf_q    <= '0;
      pc_q           <= '0;
      alu_result_q   <= '0;
      res_from_mem_q <= 1'b0;
      dest_q         <= '0;
      gr_we_q        <= 1'b0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      first_cyc_q    <= first_cyc_d;
      buf_vld_q      <= buf_vld_d;
      rdata_buf_q    <= rdata_buf_d;
      pc_q           <= pc_d;
      alu_result_q   <= alu_result_d;
      res_from_mem_q <= res_from_mem_d;
      dest_q         <= dest_d;
      gr_we_q        <= gr_we_d;
    end
  end

  // SRAM data is only live in the entry cycle; afterwards use the held copy
  assign rdata_eff = first_cyc_q ? data_sram_rdata
                                 : (buf_vld_q ? rdata_buf_q : '0);

`ifdef MEM_SUBWORD_LD_EN
  logic [2:0] ld_op_q, ld_op_d;

  always_comb begin
    ld_op_d = ld_op_q;
    if (accept) ld_op_d = es_in.ld_op;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ld_op_q <= '0;
    else         ld_op_q <= ld_op_d;
  end

  load_align u_load_align (
    .rdata (rdata_eff),
    .addr  (alu_result_q[1:0]),
    .ld_op (ld_op_q),
    .data  (load_data)
  );
`else
  logic unused_ld_op;
  assign unused_ld_op = ^es_in.ld_op;
  assign load_data    = rdata_eff;
`endif

  assign final_result = res_from_mem_q ? load_data : alu_result_q;

  ms2ws_bus_t ws_out;
  always_comb begin
    ws_out.pc           = pc_q;
    ws_out.final_result = final_result;
    ws_out.gr_we        = gr_we_q;
    ws_out.dest         = dest_q;
  end

  assign ms2ws_valid  = ms_valid_q;
  assign ms2ws_bus    = ws_out;

  assign mem_dest     = ms_valid_q ? dest_q : 5'd0;
  assign mem_rf_we    = ms_valid_q && gr_we_q;
  assign mem_fwd_data = ms_valid_q ? final_result : '0;
  assign mem_is_load  = ms_valid_q && res_from_mem_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es2ms_valid;
  logic        ms_allowin;
  logic [73:0] es2ms_bus;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [69:0] ms2ws_bus;
  logic [31:0] data_sram_rdata;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [31:0] mem_fwd_data;
  logic        mem_is_load;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin), .es2ms_bus(es2ms_bus),
    .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus),
    .data_sram_rdata(data_sram_rdata), .mem_dest(mem_dest), .mem_rf_we(mem_rf_we),
    .mem_fwd_data(mem_fwd_data), .mem_is_load(mem_is_load)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the stage holds at most one instruction plus the word
  // the SRAM returned in that instruction's entry cycle.
  logic        m_valid = 1'b0;
  logic        m_first = 1'b0;
  logic [73:0] m_ins   = '0;
  logic [31:0] m_word  = '0;

  logic        obs_vld;
  logic [31:0] obs_res;
  logic        obs_allow;

  function automatic logic [73:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic rfm, input logic [2:0] op,
                                     input logic [4:0] dest, input logic we);
    return {pc, alu, rfm, op, dest, we};
  endfunction

  function automatic logic [31:0] exp_final(input logic [73:0] ins, input logic [31:0] w);
    logic [31:0] alu;
    logic [2:0]  op;
    int unsigned b, h, sh_b, sh_h;
    alu = ins[41:10];
    op  = ins[8:6];
    if (!ins[9]) return alu;
`ifdef MEM_SUBWORD_LD_EN
    sh_b = 8 * int'(alu[1:0]);
    sh_h = 16 * int'(alu[1]);
    b = (w >> sh_b) & 32'hFF;
    h = (w >> sh_h) & 32'hFFFF;
    case (op)
      3'd1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd3: return b;
      3'd4: return h;
      default: return w;
    endcase
`else
    sh_b = 0; sh_h = 0; b = 0; h = 0;
    if (op == 3'd7) return w;
    return w;
`endif
  endfunction

  task automatic check_all(input logic wa);
    logic [31:0] fr;
    fr = exp_final(m_ins, m_word);
    chk("valid", 70'(ms2ws_valid), 70'(m_valid));
    chk("allowin", 70'(ms_allowin), 70'(!m_valid || wa));
    if (m_valid) begin
      chk("bus", ms2ws_bus, {m_ins[73:42], fr, m_ins[0], m_ins[5:1]});
      chk("rf_we", 70'(mem_rf_we), 70'(m_ins[0]));
      chk("is_load", 70'(mem_is_load), 70'(m_ins[9]));
      chk("dest", 70'(mem_dest), 70'(m_ins[5:1]));
      chk("fwd", 70'(mem_fwd_data), 70'(fr));
    end else begin
      chk("rf_we_idle", 70'(mem_rf_we), 70'd0);
      chk("is_load_idle", 70'(mem_is_load), 70'd0);
      chk("dest_idle", 70'(mem_dest), 70'd0);
      chk("fwd_idle", 70'(mem_fwd_data), 70'd0);
    end
  endtask

  // One cycle: apply inputs (just after a posedge), check at negedge, then
  // advance the model at the next posedge.
  task automatic cyc(input logic v, input logic [73:0] b, input logic wa, input logic [31:0] rd);
    es2ms_valid = v; es2ms_bus = b; ws_allowin = wa; data_sram_rdata = rd;
    if (m_first) m_word = rd;
    @(negedge clk);
    check_all(wa);
    obs_vld = ms2ws_valid; obs_res = ms2ws_bus[37:6]; obs_allow = ms_allowin;
    @(posedge clk);
    if (!m_valid || wa) begin
      m_valid = v;
      m_first = v;
      if (v) m_ins = b;
    end else begin
      m_first = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [31:0] exp032, exp033;
`ifdef MEM_SUBWORD_LD_EN
    exp032 = 32'hFFFF_FF80; exp033 = 32'h0000_8001;
`else
    exp032 = 32'h1234_80FF; exp033 = 32'h8001_0000;
`endif
    resetn = 1'b0; es2ms_valid = 1'b0; es2ms_bus = '0; ws_allowin = 1'b1;
    data_sram_rdata = '0;
    #2;
    chk("rst_valid", 70'(ms2ws_valid), 70'd0);
    chk("rst_allowin", 70'(ms_allowin), 70'd1);
    chk("rst_rf_we", 70'(mem_rf_we), 70'd0);
    chk("rst_is_load", 70'(mem_is_load), 70'd0);
    chk("rst_bus", ms2ws_bus, 70'd0);
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;

    // LD_B, byte lane 1
    cyc(1'b1, mk(32'h100, 32'h1001, 1'b1, 3'd1, 5'd3, 1'b1), 1'b1, 32'h0);
    cyc(1'b0, '0, 1'b1, 32'h1234_80FF);
    chk("ldb_res", 70'(obs_res), 70'(exp032));

    // LD_HU, upper halfword
    cyc(1'b1, mk(32'h104, 32'h1002, 1'b1, 3'd4, 5'd4, 1'b1), 1'b1, 32'h0);
    cyc(1'b0, '0, 1'b1, 32'h8001_0000);
    chk("ldhu_res", 70'(obs_res), 70'(exp033));

    // LD_W held across a WB stall while SRAM output changes
    cyc(1'b1, mk(32'h108, 32'h2000, 1'b1, 3'd0, 5'd6, 1'b1), 1'b1, 32'h0);
    cyc(1'b0, '0, 1'b0, 32'h0000_0042);
    chk("stall_res0", 70'(obs_res), 70'h42);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, mk(32'h10C, 32'h99, 1'b0, 3'd0, 5'd7, 1'b1), 1'b0, 32'hDEAD_BEEF);
      chk("stall_res", 70'(obs_res), 70'h42);
      chk("stall_allowin", 70'(obs_allow), 70'd0);
    end
    cyc(1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    chk("stall_release", 70'(obs_res), 70'h42);

    // back-to-back ALU then load, no bubble
    cyc(1'b1, mk(32'h200, 32'h10, 1'b0, 3'd0, 5'd1, 1'b1), 1'b1, 32'h0);
    cyc(1'b1, mk(32'h204, 32'h3000, 1'b1, 3'd0, 5'd2, 1'b1), 1'b1, 32'h5555);
    chk("b2b_vld0", 70'(obs_vld), 70'd1);
    chk("b2b_res0", 70'(obs_res), 70'h10);
    cyc(1'b0, '0, 1'b1, 32'h20);
    chk("b2b_vld1", 70'(obs_vld), 70'd1);
    chk("b2b_res1", 70'(obs_res), 70'h20);

    // forwarding outputs
    cyc(1'b1, mk(32'h300, 32'h7, 1'b0, 3'd0, 5'd5, 1'b1), 1'b1, 32'h0);
    cyc(1'b0, '0, 1'b1, 32'h0);
    cyc(1'b0, '0, 1'b1, 32'h0);

    // reset during a stalled load
    cyc(1'b1, mk(32'h400, 32'h4000, 1'b1, 3'd0, 5'd8, 1'b1), 1'b1, 32'h0);
    cyc(1'b0, '0, 1'b0, 32'h1111);
    es2ms_valid = 1'b0; ws_allowin = 1'b0;
    #2; resetn = 1'b0; #1;
    chk("rstmid_valid", 70'(ms2ws_valid), 70'd0);
    chk("rstmid_allowin", 70'(ms_allowin), 70'd1);
    chk("rstmid_is_load", 70'(mem_is_load), 70'd0);
    m_valid = 1'b0; m_first = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, (i != 1), 32'h2222);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [73:0] b;
      b = mk($urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             5'($urandom), 1'($urandom_range(0, 1)));
      cyc($urandom_range(0, 3) != 0, b, $urandom_range(0, 3) != 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
